sha256_mem_responder: RTL and testbench

- Memory-side responder and host front end for the SHA-256 core's memory master interface (mem_we/mem_addr/mem_write_data/mem_read_data, start/done).
- Owns the word-addressed message/hash store.
- Accepts message words from a host stream and pulses start to the core.
- Serves the core's reads and writes while it runs, then streams the 8 hash words back to the host.

---
 rtl/sha_mem_pkg.sv | 33 +++
 rtl/sha_mem_sram.sv | 59 +++++
 rtl/sha256_mem_responder.sv | 192 +++++++++++++++++++
 tb/tb_sha256_mem_responder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_mem_pkg.sv
// ---------------------------------------------------------------------------
// sha_mem_pkg
// Shared definitions for the SHA-256 memory responder:
//   - state_t    : responder FSM states
//   - HASH_WORDS : number of 32-bit hash words produced by the core
//   - DEF_*      : default sizing and address map
//   - coreOwns() : which states hand the storage array to the core port
// ---------------------------------------------------------------------------
package sha_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    DRAIN_RD,
    DRAIN_OUT
  } state_t;

  localparam int          HASH_WORDS       = 8;
  localparam int          DEF_NUM_OF_WORDS = 20;
  localparam int          DEF_DEPTH        = 64;
  localparam logic [15:0] DEF_MESSAGE_ADDR = 16'h0000;
  localparam logic [15:0] DEF_OUTPUT_ADDR  = 16'h0020;

  // The core may only touch the array while we are waiting on it; every
  // other state belongs to the host-facing load/drain logic.
  function automatic logic coreOwns(input state_t s);
    return (s == WAIT_BUSY) || (s == WAIT_DONE);
  endfunction

endpackage

// File: rtl/sha_mem_sram.sv
// ---------------------------------------------------------------------------
// sha_mem_sram
// Single write port / single registered read port word store with an
// address range check. Out-of-range writes are dropped and out-of-range
// reads return zero. The array itself is never reset; only the read
// register is.
// Ports:
//   clk      in   clock
//   reset_n  in   async active-low reset (read register only)
//   i_we     in   write enable
//   i_re     in   read enable (read register only updates when high)
//   i_addr   in   16-bit word address
//   i_wdata  in   32-bit write data
//   o_rdata  out  32-bit registered read data
// ---------------------------------------------------------------------------
module sha_mem_sram #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_we,
  input  logic        i_re,
  input  logic [15:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_rdata;
  logic          w_inRange;
  logic [AW-1:0] w_idx;

  // The index is only trusted once the full 16-bit address is in range,
  // so high address bits can never alias onto a low word.
  assign w_inRange = ({1'b0, i_addr} < DEPTH_W);
  assign w_idx     = i_addr[AW-1:0];

  always_ff @(posedge clk) begin
    if (i_we && w_inRange) begin
      r_mem[w_idx] <= i_wdata;
    end
  end

  // Read data holds between enabled reads so a consumer can keep
  // presenting it for as long as it likes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= 32'h0;
    end else if (i_re) begin
      r_rdata <= w_inRange ? r_mem[w_idx] : 32'h0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sha256_mem_responder.sv
// ---------------------------------------------------------------------------
// sha256_mem_responder
// Memory-side responder and host front end for the SHA-256 core. Loads
// NUM_OF_WORDS message words from a host stream into the message region,
// pulses sha_start, serves the core's memory port while it runs, then
// streams the 8 hash words from the output region back to the host.
// Optional feature macro: SHA_MEM_ADDR_CHK_EN adds a sticky addr_err output
// that flags any core access at or beyond DEPTH.
// Ports:
//   clk, reset_n              clock, async active-low reset
//   in_valid/in_ready/in_data host message stream (32-bit)
//   out_valid/out_ready/out_data hash stream to host (h0 first)
//   busy                      high from START through the last drain beat
//   sha_start, sha_done       core control (done idles high)
//   sha_message_addr/sha_output_addr  constant region bases for the core
//   mem_we/mem_addr/mem_write_data/mem_read_data  core memory port
//   addr_err                  (SHA_MEM_ADDR_CHK_EN only) sticky range error
// ---------------------------------------------------------------------------
module sha256_mem_responder
  import sha_mem_pkg::*;
#(
  parameter int          NUM_OF_WORDS = DEF_NUM_OF_WORDS,
  parameter int          DEPTH        = DEF_DEPTH,
  parameter logic [15:0] MESSAGE_ADDR = DEF_MESSAGE_ADDR,
  parameter logic [15:0] OUTPUT_ADDR  = DEF_OUTPUT_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        sha_start,
  input  logic        sha_done,
  output logic [15:0] sha_message_addr,
  output logic [15:0] sha_output_addr,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data
`ifdef SHA_MEM_ADDR_CHK_EN
  ,
  output logic        addr_err
`endif
);

  localparam logic [15:0] LAST_LOAD  = 16'(NUM_OF_WORDS - 1);
  localparam logic [2:0]  LAST_DRAIN = 3'(HASH_WORDS - 1);

  // The message region must not run into the hash region, and the hash
  // region must fit inside the array.
  generate
    if ((int'(MESSAGE_ADDR) + NUM_OF_WORDS > int'(OUTPUT_ADDR)) ||
        (int'(OUTPUT_ADDR) + HASH_WORDS > DEPTH)) begin : g_mapCheck
      $error("sha256_mem_responder: message/output regions overlap or exceed DEPTH");
    end
  endgenerate

  state_t      r_state;
  logic [15:0] r_loadCnt;
  logic [2:0]  r_drainCnt;
  logic        r_coreReadLast;
  logic [31:0] r_memReadHold;

  logic        w_coreOwns;
  logic        w_sramWe;
  logic        w_sramRe;
  logic [15:0] w_sramAddr;
  logic [31:0] w_sramWdata;
  logic [31:0] w_sramRdata;

  assign w_coreOwns = coreOwns(r_state);

  // Array port mux: the core drives it while we wait on it, otherwise the
  // load path writes message words and the drain path reads hash words.
  // Core writes outside its window are simply never routed to the array.
  always_comb begin
    w_sramWe    = 1'b0;
    w_sramRe    = 1'b0;
    w_sramAddr  = OUTPUT_ADDR + {13'b0, r_drainCnt};
    w_sramWdata = in_data;
    if (w_coreOwns) begin
      w_sramWe    = mem_we;
      w_sramRe    = 1'b1;
      w_sramAddr  = mem_addr;
      w_sramWdata = mem_write_data;
    end else if (r_state == LOAD) begin
      w_sramWe   = in_valid;
      w_sramAddr = MESSAGE_ADDR + r_loadCnt;
    end else if (r_state == DRAIN_RD) begin
      w_sramRe = 1'b1;
    end
  end

  sha_mem_sram #(
    .DEPTH (DEPTH)
  ) u_sram (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_sramWe),
    .i_re    (w_sramRe),
    .i_addr  (w_sramAddr),
    .i_wdata (w_sramWdata),
    .o_rdata (w_sramRdata)
  );

  // Main sequencer. WAIT_BUSY exists because the core's done is high while
  // idle: we must see it drop before a rising done means "hash ready".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_loadCnt  <= 16'h0;
      r_drainCnt <= 3'h0;
    end else begin
      case (r_state)
        IDLE: r_state <= LOAD;
        LOAD: begin
          if (in_valid) begin
            if (r_loadCnt == LAST_LOAD) begin
              r_loadCnt <= 16'h0;
              r_state   <= START;
            end else begin
              r_loadCnt <= r_loadCnt + 16'd1;
            end
          end
        end
        START: r_state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (!sha_done) r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (sha_done) r_state <= DRAIN_RD;
        end
        DRAIN_RD: r_state <= DRAIN_OUT;
        DRAIN_OUT: begin
          if (out_ready) begin
            if (r_drainCnt == LAST_DRAIN) begin
              r_drainCnt <= 3'h0;
              r_state    <= LOAD;
            end else begin
              r_drainCnt <= r_drainCnt + 3'd1;
              r_state    <= DRAIN_RD;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The shared read register is also used by the drain path, so the core
  // sees it only for reads it issued itself; afterwards its last value is
  // frozen in a hold register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_coreReadLast <= 1'b0;
      r_memReadHold  <= 32'h0;
    end else begin
      r_coreReadLast <= w_coreOwns;
      r_memReadHold  <= mem_read_data;
    end
  end

  assign mem_read_data    = r_coreReadLast ? w_sramRdata : r_memReadHold;
  assign in_ready         = (r_state == LOAD);
  assign out_valid        = (r_state == DRAIN_OUT);
  assign out_data         = out_valid ? w_sramRdata : 32'h0;
  assign sha_start        = (r_state == START);
  assign busy             = (r_state != IDLE) && (r_state != LOAD);
  assign sha_message_addr = MESSAGE_ADDR;
  assign sha_output_addr  = OUTPUT_ADDR;

`ifdef SHA_MEM_ADDR_CHK_EN
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);
  logic r_addrErr;

  // Sticky until reset so software can inspect it after the job.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addrErr <= 1'b0;
    end else if (w_coreOwns && ({1'b0, mem_addr} >= DEPTH_W)) begin
      r_addrErr <= 1'b1;
    end
  end

  assign addr_err = r_addrErr;
`endif

endmodule

// File: tb/tb_sha256_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_sha256_mem_responder
// Drives host load/drain streams and a behavioural core stub against the
// responder; expected values come from a word-array model of the store.
// ---------------------------------------------------------------------------
module tb_sha256_mem_responder;

  localparam int NW       = 20;
  localparam int DEPTH    = 64;
  localparam int HW       = 8;
  localparam int MSG_BASE = 0;
  localparam int OUT_BASE = 32;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic        sha_start;
  logic        sha_done;
  logic [15:0] sha_message_addr;
  logic [15:0] sha_output_addr;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
`ifdef SHA_MEM_ADDR_CHK_EN
  logic        addr_err;
`endif

  int          vectorCount;
  int          missCount;
  logic [31:0] refMem   [DEPTH];
  bit          refKnown [DEPTH];
  logic [31:0] msgWords [NW];
  logic [31:0] hashWords[HW];

  sha256_mem_responder #(
    .NUM_OF_WORDS (NW),
    .DEPTH        (DEPTH),
    .MESSAGE_ADDR (16'h0000),
    .OUTPUT_ADDR  (16'h0020)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .busy             (busy),
    .sha_start        (sha_start),
    .sha_done         (sha_done),
    .sha_message_addr (sha_message_addr),
    .sha_output_addr  (sha_output_addr),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
`ifdef SHA_MEM_ADDR_CHK_EN
    ,
    .addr_err         (addr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
    end
  endtask

  // Every step ends 1 time unit after a rising edge: inputs are driven and
  // outputs sampled there, well away from the edge itself.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] modelRead(input int a);
    return (a < DEPTH) ? refMem[a] : 32'h0;
  endfunction

  task automatic coreRead(input int a, input string tag);
    mem_we   = 1'b0;
    mem_addr = 16'(a);
    stepCycle();
    checkOutput(tag, mem_read_data, modelRead(a));
  endtask

  task automatic coreWrite(input int a, input logic [31:0] d);
    mem_we         = 1'b1;
    mem_addr       = 16'(a);
    mem_write_data = d;
    stepCycle();
    mem_we = 1'b0;
    if (a < DEPTH) begin
      refMem[a]   = d;
      refKnown[a] = 1'b1;
    end
  endtask

  // Host load of msgWords with random idle gaps; ends in WAIT_BUSY.
  task automatic applyStimulus(input int maxGap);
    for (int i = 0; i < NW; i++) begin
      int gap;
      gap = $urandom_range(0, maxGap);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        checkOutput("load_gap_ready", 32'(in_ready), 32'd1);
        checkOutput("load_gap_start", 32'(sha_start), 32'd0);
        stepCycle();
      end
      in_valid = 1'b1;
      in_data  = msgWords[i];
      checkOutput("load_ready", 32'(in_ready), 32'd1);
      checkOutput("load_busy", 32'(busy), 32'd0);
      stepCycle();
      refMem[MSG_BASE + i]   = msgWords[i];
      refKnown[MSG_BASE + i] = 1'b1;
    end
    in_valid = 1'b0;
    checkOutput("start_pulse", 32'(sha_start), 32'd1);
    checkOutput("start_busy", 32'(busy), 32'd1);
    checkOutput("start_in_ready", 32'(in_ready), 32'd0);
    stepCycle();
    checkOutput("start_single", 32'(sha_start), 32'd0);
  endtask

  // Core stub keeps done high a few cycles, then drops it.
  task automatic coreEnterWait();
    int hold;
    hold     = $urandom_range(1, 3);
    mem_we   = 1'b0;
    mem_addr = 16'h0;
    in_valid = 1'b1;
    in_data  = $urandom;
    for (int c = 0; c < hold; c++) begin
      stepCycle();
      checkOutput("wait_busy", 32'(busy), 32'd1);
      checkOutput("wait_in_ready", 32'(in_ready), 32'd0);
      checkOutput("wait_out_valid", 32'(out_valid), 32'd0);
    end
    sha_done = 1'b0;
    stepCycle();
    in_valid = 1'b0;
  endtask

  // Core stub job body: reads, hash writes, out-of-range access, done rise.
  task automatic coreJob();
    int pre;
    int rnd;
    pre = $urandom_range(0, HW - 1);
    rnd = $urandom_range(0, NW - 1);
    coreRead(MSG_BASE + 5, "core_read_msg5");
    coreRead(MSG_BASE + rnd, "core_read_msg_rand");
    if (refKnown[OUT_BASE + pre]) coreRead(OUT_BASE + pre, "core_read_old_hash");
    for (int j = 0; j < HW; j++) coreWrite(OUT_BASE + j, hashWords[j]);
    coreWrite(DEPTH, $urandom);
`ifdef SHA_MEM_ADDR_CHK_EN
    checkOutput("addr_err_set", 32'(addr_err), 32'd1);
`endif
    coreRead(DEPTH, "core_read_oob");
    coreRead(MSG_BASE, "core_read_alias0");
    coreRead(OUT_BASE + pre, "core_read_new_hash");
    mem_we   = 1'b0;
    mem_addr = 16'(MSG_BASE + 5);
    sha_done = 1'b1;
    stepCycle();
    checkOutput("done_read_value", mem_read_data, refMem[MSG_BASE + 5]);
    checkOutput("drain_rd_no_valid", 32'(out_valid), 32'd0);
  endtask

  // Host drain; junk core writes are driven throughout and must be ignored.
  task automatic drainHash(input int stall0, input bit alwaysReady);
    logic [31:0] heldRead;
    heldRead  = refMem[MSG_BASE + 5];
    out_ready = alwaysReady;
    for (int k = 0; k < HW; k++) begin
      int          cyc;
      int          stall;
      logic [31:0] expWord;
      cyc = 0;
      while (!out_valid && cyc < 6) begin
        mem_we         = 1'b1;
        mem_addr       = 16'(OUT_BASE + $urandom_range(0, HW - 1));
        mem_write_data = $urandom;
        stepCycle();
        cyc++;
      end
      checkOutput("drain_valid", 32'(out_valid), 32'd1);
      checkOutput("drain_gap_cycles", 32'(cyc), 32'd1);
      expWord = refMem[OUT_BASE + k];
      stall   = (k == 0) ? stall0 : (alwaysReady ? 0 : int'($urandom_range(0, 2)));
      if (stall > 0) out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        checkOutput("drain_stall_data", out_data, expWord);
        checkOutput("drain_stall_valid", 32'(out_valid), 32'd1);
        stepCycle();
      end
      checkOutput("drain_data", out_data, expWord);
      checkOutput("drain_mem_hold", mem_read_data, heldRead);
      checkOutput("drain_busy", 32'(busy), 32'd1);
      out_ready = 1'b1;
      stepCycle();
      out_ready = alwaysReady;
    end
    mem_we    = 1'b0;
    out_ready = 1'b0;
    checkOutput("post_drain_ready", 32'(in_ready), 32'd1);
    checkOutput("post_drain_busy", 32'(busy), 32'd0);
    checkOutput("post_drain_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_sha_start"}, 32'(sha_start), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_out_data"}, out_data, 32'h0);
    checkOutput({tag, "_mem_rdata"}, mem_read_data, 32'h0);
`ifdef SHA_MEM_ADDR_CHK_EN
    checkOutput({tag, "_addr_err"}, 32'(addr_err), 32'd0);
`endif
  endtask

  task automatic releaseReset();
    reset_n = 1'b1;
    checkOutput("idle_in_ready", 32'(in_ready), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    stepCycle();
    checkOutput("load_entry_ready", 32'(in_ready), 32'd1);
    checkOutput("load_entry_start", 32'(sha_start), 32'd0);
    checkOutput("load_entry_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    vectorCount    = 0;
    missCount      = 0;
    reset_n        = 1'b0;
    in_valid       = 1'b0;
    in_data        = 32'h0;
    out_ready      = 1'b0;
    sha_done       = 1'b1;
    mem_we         = 1'b0;
    mem_addr       = 16'h0;
    mem_write_data = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      refMem[i]   = 32'h0;
      refKnown[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    checkOutput("msg_addr", 32'(sha_message_addr), 32'(MSG_BASE));
    checkOutput("out_addr", 32'(sha_output_addr), 32'(OUT_BASE));
    releaseReset();

    // Job 1: counting message, recognisable hash, 3-cycle host stall.
    for (int i = 0; i < NW; i++) msgWords[i] = 32'(i + 1);
    for (int j = 0; j < HW; j++) hashWords[j] = 32'hDEADBEEF + 32'(j);
    applyStimulus(2);
    coreEnterWait();
    coreJob();
    drainHash(3, 1'b0);

    // Job 2: aborted by reset while the core is running.
    for (int i = 0; i < NW; i++) msgWords[i] = $urandom;
    applyStimulus(1);
    coreEnterWait();
    coreRead(MSG_BASE + 3, "abort_read3");
    mem_addr = 16'h7;
    reset_n  = 1'b0;
    #1;
    checkAllZero("abort");
    sha_done = 1'b1;
    mem_addr = 16'h0;
    stepCycle();
    checkOutput("reset_hold_start", 32'(sha_start), 32'd0);
    releaseReset();

    // Job 3: random data, host always ready (full drain throughput).
    for (int i = 0; i < NW; i++) msgWords[i] = $urandom;
    for (int j = 0; j < HW; j++) hashWords[j] = $urandom;
    applyStimulus(0);
    coreEnterWait();
    coreJob();
    drainHash(0, 1'b1);
`ifdef SHA_MEM_ADDR_CHK_EN
    checkOutput("addr_err_sticky", 32'(addr_err), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
